// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM encoding and instruction fields.
package alu_seq_pkg;

    localparam int INSTR_W = 9;
    localparam int OP_MSB  = 8;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS1_MSB = 3;
    localparam int RS1_LSB = 2;
    localparam int RS2_MSB = 1;
    localparam int RS2_LSB = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        EXEC = 2'b10,
        WB   = 2'b11
    } state_t;

    // Op codes above NOT are undefined and take the short READ->WB path.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear.
module alu_seq_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr_a,
    input  logic [1:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_r [4];

    // Storage with asynchronous clear and single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            regs_r[waddr] <= wdata;
        end
    end

    assign rdata_a = regs_r[raddr_a];
    assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer driving an external combinational ALU.
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to add the zero_flag output.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               ld_valid,
    input  logic [1:0]         ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    output logic [2:0]         alu_control,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               done,
    output logic [DATA_W-1:0]  wb_data,
    output logic               illegal
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic               zero_flag
`endif
);

    state_t            state_r, state_nxt_s;
    logic [2:0]        op_r;
    logic [1:0]        rd_r;
    logic [DATA_W-1:0] result_r, wb_data_r, alu_a_r, alu_b_r;
    logic [2:0]        alu_control_r;
    logic              done_r, illegal_r;
    logic              accept_s, op_legal_s, wb_fire_s, rf_we_s;
    logic [1:0]        rf_waddr_s;
    logic [DATA_W-1:0] rf_wdata_s, rdata_a_s, rdata_b_s, a_fwd_s, b_fwd_s;
    logic [2:0]        op_in_s;
    logic [1:0]        rs1_in_s, rs2_in_s;

    assign op_in_s     = instr[OP_MSB:OP_LSB];
    assign rs1_in_s    = instr[RS1_MSB:RS1_LSB];
    assign rs2_in_s    = instr[RS2_MSB:RS2_LSB];
    assign instr_ready = (state_r == IDLE);
    assign accept_s    = instr_valid && (state_r == IDLE);
    assign op_legal_s  = op_is_legal(op_r);

    alu_seq_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we_s),
        .waddr   (rf_waddr_s),
        .wdata   (rf_wdata_s),
        .raddr_a (rs1_in_s),
        .raddr_b (rs2_in_s),
        .rdata_a (rdata_a_s),
        .rdata_b (rdata_b_s)
    );

    // Operands are captured on the accept edge, so a same-cycle preload must be forwarded.
    assign a_fwd_s = (ld_valid && (ld_addr == rs1_in_s)) ? ld_data : rdata_a_s;
    assign b_fwd_s = (op_in_s == OP_NOT) ? '0 :
                     ((ld_valid && (ld_addr == rs2_in_s)) ? ld_data : rdata_b_s);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state and register-file write control.
    always_comb begin
        state_nxt_s = state_r;
        rf_we_s     = 1'b0;
        rf_waddr_s  = ld_addr;
        rf_wdata_s  = ld_data;
        wb_fire_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ld_valid) rf_we_s = 1'b1;
                else          rf_we_s = 1'b0;
                if (instr_valid) state_nxt_s = READ;
                else             state_nxt_s = IDLE;
            end
            READ: begin
                if (op_legal_s) state_nxt_s = EXEC;
                else            state_nxt_s = WB;
            end
            EXEC: state_nxt_s = WB;
            WB: begin
                state_nxt_s = IDLE;
                wb_fire_s   = 1'b1;
                if (op_legal_s) begin
                    rf_we_s    = 1'b1;
                    rf_waddr_s = rd_r;
                    rf_wdata_s = result_r;
                end else begin
                    rf_we_s    = 1'b0;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Latched instruction fields and ALU operand drive; operands return to zero on leaving EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r          <= 3'd0;
            rd_r          <= 2'd0;
            alu_control_r <= 3'd0;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
        end else if (accept_s) begin
            op_r          <= op_in_s;
            rd_r          <= instr[RD_MSB:RD_LSB];
            alu_control_r <= op_in_s;
            alu_a_r       <= a_fwd_s;
            alu_b_r       <= b_fwd_s;
        end else if (state_nxt_s == WB) begin
            alu_control_r <= 3'd0;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
        end
    end

    // Result capture, write-back data and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r  <= '0;
            wb_data_r <= '0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            if (state_r == EXEC) result_r <= alu_result;
            if (wb_fire_s && op_legal_s) wb_data_r <= result_r;
            done_r    <= wb_fire_s;
            illegal_r <= wb_fire_s && !op_legal_s;
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zero_flag_r;

    // Zero flag follows legal write-backs only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       zero_flag_r <= 1'b0;
        else if (wb_fire_s && op_legal_s) zero_flag_r <= (result_r == '0);
    end

    assign zero_flag = zero_flag_r;
`endif

    assign alu_control = alu_control_r;
    assign alu_a       = alu_a_r;
    assign alu_b       = alu_b_r;
    assign done        = done_r;
    assign illegal     = illegal_r;
    assign wb_data     = wb_data_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions, expected write-backs queued
// at issue and checked by an independent monitor when done pulses.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [8:0] instr = 9'd0;
    logic       ld_valid = 1'b0;
    logic [1:0] ld_addr = 2'd0;
    logic [7:0] ld_data = 8'd0;
    logic [2:0] alu_control;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       done, illegal;
    logic [7:0] wb_data;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic       zero_flag;
`endif

    typedef struct {
        logic [7:0] wb;
        logic       ill;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU attached to the sequencer.
    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = ~alu_a;
            default: alu_result = 8'h00;
        endcase
    end

    alu_sequencer #(.DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .done        (done),
        .wb_data     (wb_data),
        .illegal     (illegal)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .zero_flag   (zero_flag)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (rst_n && illegal && !done) chk("illegal_without_done", 32'(illegal), 32'(0));
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_data", 32'(wb_data), 32'(e.wb));
                chk("illegal", 32'(illegal), 32'(e.ill));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    // Offers an instruction and returns at the first falling edge after it is accepted.
    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] exp_wb, input logic exp_ill,
                         input bit keep_valid, input bit push, output int acc_cyc);
        bit ok = 1'b0;
        instr       = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'(0), 32'(1));
        @(negedge clk);
        acc_cyc = cyc;
        if (!keep_valid) instr_valid = 1'b0;
        if (push) sb.push_back('{exp_wb, exp_ill, cyc + (exp_ill ? 2 : 3)});
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("done_timeout", 32'(sb.size()), 32'(0));
        @(negedge clk);
    endtask

    task automatic chk_regs(input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        chk("r0", 32'(dut.u_regfile.regs_r[0]), 32'(e0));
        chk("r1", 32'(dut.u_regfile.regs_r[1]), 32'(e1));
        chk("r2", 32'(dut.u_regfile.regs_r[2]), 32'(e2));
        chk("r3", 32'(dut.u_regfile.regs_r[3]), 32'(e3));
    endtask

    initial begin
        int acc1, acc2;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'(1));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_illegal", 32'(illegal), 32'(0));
        chk("rst_wb_data", 32'(wb_data), 32'(0));
        chk("rst_alu_control", 32'(alu_control), 32'(0));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        chk("rst_alu_b", 32'(alu_b), 32'(0));
        chk_regs(8'h00, 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD and SUB with wrap-around.
        preload(2'd0, 8'h0A);
        preload(2'd1, 8'h05);
        issue(3'b000, 2'd2, 2'd0, 2'd1, 8'h0F, 1'b0, 1'b0, 1'b1, acc1);
        chk("add_read_ctl", 32'(alu_control), 32'(3'b000));
        chk("add_read_b", 32'(alu_b), 32'(8'h05));
        drain();
        chk("idle_alu_a", 32'(alu_a), 32'(0));
        chk("idle_alu_ctl", 32'(alu_control), 32'(0));
        issue(3'b001, 2'd3, 2'd1, 2'd0, 8'hFB, 1'b0, 1'b0, 1'b1, acc1);
        drain();
        chk_regs(8'h0A, 8'h05, 8'h0F, 8'hFB);

        // AND, then OR with rd equal to rs1.
        issue(3'b010, 2'd1, 2'd2, 2'd3, 8'h0B, 1'b0, 1'b0, 1'b1, acc1);
        drain();
        issue(3'b011, 2'd1, 2'd1, 2'd3, 8'hFB, 1'b0, 1'b0, 1'b1, acc1);
        drain();
        chk_regs(8'h0A, 8'hFB, 8'h0F, 8'hFB);

        // NOT forces operand B to zero.
        preload(2'd0, 8'hF0);
        issue(3'b100, 2'd1, 2'd0, 2'd3, 8'h0F, 1'b0, 1'b0, 1'b1, acc1);
        chk("not_read_ctl", 32'(alu_control), 32'(3'b100));
        chk("not_read_a", 32'(alu_a), 32'(8'hF0));
        chk("not_read_b", 32'(alu_b), 32'(0));
        @(negedge clk);
        chk("not_exec_b", 32'(alu_b), 32'(0));
        drain();
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("zero_flag_not", 32'(zero_flag), 32'(0));
`endif
        issue(3'b001, 2'd2, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, acc1);
        drain();
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk("zero_flag_sub0", 32'(zero_flag), 32'(1));
`endif
        chk_regs(8'hF0, 8'h0F, 8'h00, 8'hFB);

        // Preload and accept in the same cycle: READ sees the new value.
        ld_valid = 1'b1;
        ld_addr  = 2'd2;
        ld_data  = 8'h21;
        issue(3'b000, 2'd3, 2'd2, 2'd2, 8'h42, 1'b0, 1'b0, 1'b1, acc1);
        ld_valid = 1'b0;
        chk("fwd_read_a", 32'(alu_a), 32'(8'h21));
        drain();

        // Undefined ops: short path, no write, wb_data held.
        issue(3'b101, 2'd0, 2'd1, 2'd2, 8'h42, 1'b1, 1'b0, 1'b1, acc1);
        drain();
        issue(3'b111, 2'd3, 2'd0, 2'd0, 8'h42, 1'b1, 1'b0, 1'b1, acc1);
        drain();
        chk_regs(8'hF0, 8'h0F, 8'h21, 8'h42);

        // Reset during EXEC aborts the instruction.
        issue(3'b000, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0, acc1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_ready", 32'(instr_ready), 32'(1));
        chk("abort_wb_data", 32'(wb_data), 32'(0));
        chk_regs(8'h00, 8'h00, 8'h00, 8'h00);

        // Back-to-back ADDs with valid held high; a preload during READ is ignored.
        preload(2'd0, 8'h0A);
        preload(2'd1, 8'h05);
        issue(3'b000, 2'd2, 2'd0, 2'd1, 8'h0F, 1'b0, 1'b1, 1'b1, acc1);
        instr    = {3'b000, 2'd3, 2'd0, 2'd2};
        ld_valid = 1'b1;
        ld_addr  = 2'd0;
        ld_data  = 8'hFF;
        @(negedge clk);
        ld_valid = 1'b0;
        issue(3'b000, 2'd3, 2'd0, 2'd2, 8'h19, 1'b0, 1'b0, 1'b1, acc2);
        chk("b2b_accept", 32'(acc2), 32'(acc1 + 4));
        drain();
        chk_regs(8'h0A, 8'h05, 8'h0F, 8'h19);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
